// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: state encodings, flag values,
// widths and the {remainder, quotient} result payload.
package div_unit_pkg;

  localparam int unsigned DataW   = 32;
  localparam int unsigned PartW   = 2 * DataW + 1;
  localparam int unsigned CntW    = 6;
  localparam int unsigned NumIter = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [DataW-1:0] ZeroWord = '0;

  typedef struct packed {
    logic [DataW-1:0] rem;
    logic [DataW-1:0] quo;
  } div_result_t;

  // Two's-complement negate of a word.
  function automatic logic [DataW-1:0] neg_word(input logic [DataW-1:0] x);
    return ~x + DataW'(1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   partial  in  65  {rem[32:0], quo[31:0]} before the step
//   divisor  in  32  divisor magnitude
//   next_c   out 65  partial after shift, trial subtract and quotient bit
module div_step
  import div_unit_pkg::*;
(
  input  logic [PartW-1:0] partial,
  input  logic [DataW-1:0] divisor,
  output logic [PartW-1:0] next_c
);

  logic [PartW-1:0] shifted;
  logic [DataW:0]   diff;

  // Shift, trial-subtract from the upper 33 bits, keep or restore.
  always_comb begin
    shifted = partial << 1;
    diff    = shifted[PartW-1:DataW] - {1'b0, divisor};
    next_c  = shifted;
    if (!diff[DataW]) begin
      next_c = {diff, shifted[DataW-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit integer divider for DIV/DIVU in the execute stage.
// Signed support is compiled in only when DIV_SIGNED_EN is defined; otherwise
// every operation is unsigned and signed_div_i is ignored.
// Ports:
//   clk           in   1  clock
//   rst           in   1  asynchronous active-low reset
//   signed_div_i  in   1  1 = signed divide
//   opdata1_i     in  32  dividend
//   opdata2_i     in  32  divisor
//   start_i       in   1  request, held until ready_o seen
//   annul_i       in   1  abort the operation in progress
//   result_o      out 64  {remainder, quotient}
//   ready_o       out  1  result_o valid
module div_unit
  import div_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [DataW-1:0]   opdata1_i,
  input  logic [DataW-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*DataW-1:0] result_o,
  output logic               ready_o
);

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PartW-1:0] part_q, part_d;
  logic [DataW-1:0] dvd_q, dvd_d;
  logic [DataW-1:0] dvs_q, dvs_d;
  div_result_t      res_d;
  logic             ready_d;

  logic [DataW-1:0] dvd_mag_c, dvs_mag_c;
  logic [DataW-1:0] quo_fix, rem_fix;
  logic [PartW-1:0] step_in, step_out;
  logic             part_msb_unused;

`ifdef DIV_SIGNED_EN
  logic sgn_q, sgn_d;
  logic dvd_neg_q, dvd_neg_d;
  logic dvs_neg_q, dvs_neg_d;

  // Operand magnitudes for signed requests.
  assign dvd_mag_c = (signed_div_i && opdata1_i[DataW-1]) ? neg_word(opdata1_i) : opdata1_i;
  assign dvs_mag_c = (signed_div_i && opdata2_i[DataW-1]) ? neg_word(opdata2_i) : opdata2_i;

  // Sign fix-up of the unsigned result.
  assign quo_fix = (sgn_q && (dvd_neg_q ^ dvs_neg_q)) ? neg_word(part_q[DataW-1:0])
                                                     : part_q[DataW-1:0];
  assign rem_fix = (sgn_q && dvd_neg_q) ? neg_word(part_q[2*DataW-1:DataW])
                                        : part_q[2*DataW-1:DataW];
`else
  logic sign_unused;

  assign sign_unused = signed_div_i;
  assign dvd_mag_c   = opdata1_i;
  assign dvs_mag_c   = opdata2_i;
  assign quo_fix     = part_q[DataW-1:0];
  assign rem_fix     = part_q[2*DataW-1:DataW];
`endif

  // Remainder never exceeds 32 bits once all iterations are done.
  assign part_msb_unused = part_q[PartW-1];

  // Partial register is cleared on entry; the dividend feeds the first step.
  assign step_in = (cnt_q == '0) ? PartW'(dvd_q) : part_q;

  div_step u_div_step (
    .partial (step_in),
    .divisor (dvs_q),
    .next_c  (step_out)
  );

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      part_q    <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      result_o  <= '0;
      ready_o   <= DivResultNotReady;
`ifdef DIV_SIGNED_EN
      sgn_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      part_q    <= part_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      result_o  <= res_d;
      ready_o   <= ready_d;
`ifdef DIV_SIGNED_EN
      sgn_q     <= sgn_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    res_d   = result_o;
    ready_d = DivResultNotReady;
`ifdef DIV_SIGNED_EN
    sgn_d     = sgn_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
`endif
    case (state_q)
      DivFree: begin
        res_d = '0;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == ZeroWord) begin
            state_d = DivByZero;
          end else begin
            state_d = DivOn;
            dvd_d   = dvd_mag_c;
            dvs_d   = dvs_mag_c;
            cnt_d   = '0;
            part_d  = '0;
`ifdef DIV_SIGNED_EN
            sgn_d     = signed_div_i;
            dvd_neg_d = opdata1_i[DataW-1];
            dvs_neg_d = opdata2_i[DataW-1];
`endif
          end
        end
      end
      DivByZero: begin
        state_d = DivEnd;
        res_d   = '0;
      end
      DivOn: begin
        res_d = '0;
        if (annul_i) begin
          state_d = DivFree;
        end else if (cnt_q != CntW'(NumIter)) begin
          part_d = step_out;
          cnt_d  = cnt_q + CntW'(1);
        end else begin
          res_d.rem = rem_fix;
          res_d.quo = quo_fix;
          ready_d   = DivResultReady;
          state_d   = DivEnd;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          state_d = DivFree;
          res_d   = '0;
        end else begin
          ready_d = DivResultReady;
        end
      end
      default: begin
        state_d = DivFree;
        res_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with an arithmetic reference model and a
// per-cycle output compare process.
module tb_div_unit;

  localparam int Big = 1 << 30;
`ifdef DIV_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ready_from = Big;
  int          ready_to = Big;
  logic [63:0] exp_res = '0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division with the divider's conventions.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn && SignedEn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = int'(a);
      sb = int'(b);
      q  = sa / sb;
      r  = sa % sb;
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  // Per-cycle compare of ready_o (and result_o while ready).
  always @(posedge clk) begin
    logic exp_r;
    #2;
    exp_r = (cyc >= ready_from) && (cyc < ready_to);
    check("ready_o", 64'(ready), 64'(exp_r));
    if (exp_r) check("result_o", result, exp_res);
  end

  // Issue a request (called just after a negedge with the unit idle),
  // hold it `hold` cycles past ready, then release.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] lit, input int hold);
    int e, lat, waited;
    lat        = (b == 32'h0) ? 2 : 33;
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    e          = cyc + 1;
    exp_res    = ref_div(sgn, a, b);
    ready_from = e + lat;
    ready_to   = Big;
    @(negedge clk);
    op1        = 32'hDEAD_BEEF;
    op2        = 32'h0;
    signed_div = ~sgn;
    waited     = 0;
    while (!ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("latency", 64'(cyc - e), 64'(lat));
    check("literal", result, lit);
    repeat (hold) @(negedge clk);
    start    = 1'b0;
    ready_to = cyc + 1;
    @(negedge clk);
    check("release_ready", 64'(ready), 64'h0);
    check("release_result", result, 64'h0);
  endtask

  initial begin
    int e;
    rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("reset_ready", 64'(ready), 64'h0);
    check("reset_result", result, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 3);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2,
           SignedEn ? 64'hFFFFFFFF_FFFFFFFD : 64'h00000001_7FFFFFFC, 1);
    do_div(1'b0, 32'd1234, 32'd0, 64'h0, 4);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           SignedEn ? 64'h00000000_80000000 : 64'h80000000_00000000, 0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE,
           SignedEn ? 64'h00000001_FFFFFFFD : 64'h00000007_00000000, 1);
    do_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
           SignedEn ? 64'hFFFFFFFE_0000000E : 64'hFFFFFF9C_00000000, 1);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, 0);
    do_div(1'b0, 32'd5, 32'd9, 64'h00000005_00000000, 2);

    // Annul in the 10th DIV_ON cycle, then a new request on the next edge.
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    e = cyc + 1;
    ready_from = e + 33; ready_to = Big; exp_res = ref_div(1'b0, 32'd1000, 32'd3);
    @(negedge clk);
    repeat (9) @(negedge clk);
    annul = 1'b1;
    ready_from = Big;
    @(negedge clk);
    annul = 1'b0;
    do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1);

    // Asynchronous reset while iterating.
    signed_div = 1'b0; op1 = 32'd77; op2 = 32'd4; start = 1'b1;
    ready_from = Big; ready_to = Big;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_on_ready", 64'(ready), 64'h0);
    check("rst_on_result", result, 64'h0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Asynchronous reset while a result is presented.
    signed_div = 1'b0; op1 = 32'd50; op2 = 32'd5; start = 1'b1;
    e = cyc + 1;
    ready_from = e + 33; ready_to = Big; exp_res = ref_div(1'b0, 32'd50, 32'd5);
    @(negedge clk);
    for (int i = 0; i < 40 && !ready; i++) @(negedge clk);
    check("end_result", result, 64'h00000000_0000000A);
    #2;
    ready_from = Big;
    rst = 1'b0;
    #1;
    check("rst_end_ready", 64'(ready), 64'h0);
    check("rst_end_result", result, 64'h0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fresh operation after reset.
    do_div(1'b1, 32'd100, 32'd10, 64'h00000000_0000000A, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
